boom_axi_mem_bridge: RTL and testbench

BOOM_AXI_MEM_BRIDGE -- requirements
Module: boom_axi_mem_bridge

---
 rtl/boom_axi_mem_pkg.sv | 41 ++++
 rtl/boom_axi_burst_addr.sv | 22 ++
 rtl/boom_axi_mem_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_boom_axi_mem_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boom_axi_mem_pkg.sv
// Shared types and helpers for the AXI-to-SRAM bridge: FSM states, AXI burst and
// response encodings, and the next-beat address calculation.
package boom_axi_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_RESP,
        S_WR_DATA,
        S_WR_RESP
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Computed at 64 bits; callers truncate to their address width, which also
    // gives the modulo-2^ADDR_WIDTH wrap of INCR bursts.
    function automatic logic [63:0] beat_addr_next(input logic [63:0] addr,
                                                   input logic [2:0]  size,
                                                   input logic [7:0]  len,
                                                   input logic [1:0]  burst,
                                                   input logic        wrap_en);
        logic [63:0] step;
        logic [63:0] sum;
        logic [63:0] mask;
        step = 64'd1 << size;
        sum  = addr + step;
        mask = ((64'(len) + 64'd1) << size) - 64'd1;
        if (burst == BURST_FIXED)
            return addr;
        if (burst == BURST_WRAP && wrap_en)
            return (addr & ~mask) | (sum & mask);
        return sum;
    endfunction

endpackage

// File: rtl/boom_axi_burst_addr.sv
// Beat address generator: next address of a burst and the memory-word-aligned
// address of the current beat.
module boom_axi_burst_addr
    import boom_axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter bit WRAP_EN    = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_o,
    output logic [ADDR_WIDTH-1:0] aligned_o
);
    localparam int BLOG = $clog2(DATA_WIDTH / 8);

    assign next_o    = ADDR_WIDTH'(beat_addr_next(64'(addr_i), size_i, len_i, burst_i, WRAP_EN));
    assign aligned_o = {addr_i[ADDR_WIDTH-1:BLOG], {BLOG{1'b0}}};

endmodule

// File: rtl/boom_axi_mem_bridge.sv
// AXI4 slave to single-port synchronous memory bridge, one burst at a time.
// Define BOOM_AXI_MEM_WRAP_EN to support WRAP bursts (otherwise WRAP behaves as INCR).
module boom_axi_mem_bridge
    import boom_axi_mem_pkg::*;
#(
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset_wire_reset,
    input  logic                    aw_valid_i,
    input  logic [ID_WIDTH-1:0]     aw_id_i,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [7:0]              aw_len_i,
    input  logic [2:0]              aw_size_i,
    input  logic [1:0]              aw_burst_i,
    output logic                    aw_ready_o,
    input  logic                    w_valid_i,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                    w_last_i,
    output logic                    w_ready_o,
    output logic                    b_valid_o,
    output logic [ID_WIDTH-1:0]     b_id_o,
    output logic [1:0]              b_resp_o,
    input  logic                    b_ready_i,
    input  logic                    ar_valid_i,
    input  logic [ID_WIDTH-1:0]     ar_id_i,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [7:0]              ar_len_i,
    input  logic [2:0]              ar_size_i,
    input  logic [1:0]              ar_burst_i,
    output logic                    ar_ready_o,
    output logic                    r_valid_o,
    output logic [ID_WIDTH-1:0]     r_id_o,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o,
    input  logic                    r_ready_i,
    output logic                    req_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH/8-1:0] be_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    input  logic [DATA_WIDTH-1:0]   data_i
);
    localparam int BLOG = $clog2(DATA_WIDTH / 8);
`ifdef BOOM_AXI_MEM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d, beat_q, beat_d;
    logic [2:0]              size_q, size_d, cnt_q, cnt_d;
    logic [1:0]              burst_q, burst_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d, mism_q, mism_d, drop_q, drop_d;
    logic                    rr_q, rr_d, ar_rdy_q, ar_rdy_d, aw_rdy_q, aw_rdy_d;

    logic [ADDR_WIDTH-1:0]   next_addr, beat_addr, in_addr;
    logic [ID_WIDTH-1:0]     in_id;
    logic [7:0]              in_len;
    logic [2:0]              in_size;
    logic [1:0]              in_burst;
    logic                    last_beat, wr_req, in_bad;

    boom_axi_burst_addr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .WRAP_EN   (WRAP_EN)
    ) u_burst_addr (
        .addr_i   (addr_q),
        .size_i   (size_q),
        .len_i    (len_q),
        .burst_i  (burst_q),
        .next_o   (next_addr),
        .aligned_o(beat_addr)
    );

    // Address channel whose ready was raised last cycle supplies the burst.
    assign in_id    = ar_rdy_q ? ar_id_i    : aw_id_i;
    assign in_addr  = ar_rdy_q ? ar_addr_i  : aw_addr_i;
    assign in_len   = ar_rdy_q ? ar_len_i   : aw_len_i;
    assign in_size  = ar_rdy_q ? ar_size_i  : aw_size_i;
    assign in_burst = ar_rdy_q ? ar_burst_i : aw_burst_i;
    assign in_bad   = (in_size > 3'(BLOG)) ||
                      (WRAP_EN && in_burst == BURST_WRAP &&
                       !(in_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

    assign last_beat = (beat_q == len_q);
    assign wr_req    = (state_q == S_WR_DATA) && w_valid_i && !drop_q && !err_q;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mism_d   = mism_q;
        drop_d   = drop_q;
        rr_d     = rr_q;
        ar_rdy_d = 1'b0;
        aw_rdy_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Ready is registered, so a grant costs one cycle but keeps
                // valid-to-ready free of combinational paths.
                if (ar_rdy_q || aw_rdy_q) begin
                    if ((ar_rdy_q && ar_valid_i) || (aw_rdy_q && aw_valid_i)) begin
                        id_d    = in_id;
                        addr_d  = in_addr;
                        len_d   = in_len;
                        size_d  = in_size;
                        burst_d = in_burst;
                        err_d   = in_bad;
                        beat_d  = '0;
                        mism_d  = 1'b0;
                        drop_d  = 1'b0;
                        rr_d    = ar_rdy_q;
                        state_d = ar_rdy_q ? S_RD_REQ : S_WR_DATA;
                    end
                end else if (ar_valid_i && (!aw_valid_i || !rr_q)) begin
                    ar_rdy_d = 1'b1;
                end else if (aw_valid_i) begin
                    aw_rdy_d = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (err_q) begin
                    rdata_d = '0;
                    state_d = S_RD_RESP;
                end else begin
                    cnt_d   = 3'd1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == 3'(MEM_LATENCY)) begin
                    rdata_d = data_i;
                    state_d = S_RD_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RD_RESP: begin
                if (r_ready_i) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_WR_DATA: begin
                // Beats past len+1 are swallowed until w_last so the master can finish.
                if (w_valid_i) begin
                    if (drop_q) begin
                        if (w_last_i) state_d = S_WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = next_addr;
                        if (w_last_i != last_beat) mism_d = 1'b1;
                        if (w_last_i)       state_d = S_WR_RESP;
                        else if (last_beat) drop_d  = 1'b1;
                    end
                end
            end
            S_WR_RESP: begin
                if (b_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset_wire_reset) begin
        if (reset_wire_reset) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mism_q   <= 1'b0;
            drop_q   <= 1'b0;
            rr_q     <= 1'b0;
            ar_rdy_q <= 1'b0;
            aw_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mism_q   <= mism_d;
            drop_q   <= drop_d;
            rr_q     <= rr_d;
            ar_rdy_q <= ar_rdy_d;
            aw_rdy_q <= aw_rdy_d;
        end
    end

    assign ar_ready_o = ar_rdy_q;
    assign aw_ready_o = aw_rdy_q;
    assign w_ready_o  = (state_q == S_WR_DATA);
    assign r_valid_o  = (state_q == S_RD_RESP);
    assign r_id_o     = id_q;
    assign r_data_o   = rdata_q;
    assign r_resp_o   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign r_last_o   = (state_q == S_RD_RESP) && last_beat;
    assign b_valid_o  = (state_q == S_WR_RESP);
    assign b_id_o     = id_q;
    assign b_resp_o   = (err_q || mism_q) ? RESP_SLVERR : RESP_OKAY;

    assign req_o  = ((state_q == S_RD_REQ) && !err_q) || wr_req;
    assign we_o   = wr_req;
    assign addr_o = beat_addr;
    assign be_o   = wr_req ? w_strb_i : '0;
    assign data_o = wr_req ? w_data_i : '0;

endmodule

// File: tb/tb_boom_axi_mem_bridge.sv
// Directed bench for boom_axi_mem_bridge: memory model plus negedge monitor logs,
// checked against hand-computed addresses, strobes, data and responses.
module tb_boom_axi_mem_bridge;
    logic        clock, rst;
    logic        aw_valid, aw_ready, w_valid, w_last, w_ready;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr, addr_o;
    logic [7:0]  aw_len, ar_len, w_strb, be_o;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic [63:0] w_data, r_data, data_o, data_i;
    logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_last, r_ready;
    logic        req_o, we_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rq_addr[$];
    logic        rq_we[$];
    logic [7:0]  rq_be[$];
    logic [63:0] rq_data[$];
    logic [63:0] rb_data[$];
    logic [1:0]  rb_resp[$];
    logic        rb_last[$];
    logic [1:0]  bq_resp[$];
    logic        gnt_q[$];

    boom_axi_mem_bridge dut (
        .clock(clock), .reset_wire_reset(rst),
        .aw_valid_i(aw_valid), .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .aw_size_i(aw_size), .aw_burst_i(aw_burst), .aw_ready_o(aw_ready),
        .w_valid_i(w_valid), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
        .w_ready_o(w_ready),
        .b_valid_o(b_valid), .b_id_o(b_id), .b_resp_o(b_resp), .b_ready_i(b_ready),
        .ar_valid_i(ar_valid), .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .ar_size_i(ar_size), .ar_burst_i(ar_burst), .ar_ready_o(ar_ready),
        .r_valid_o(r_valid), .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp),
        .r_last_o(r_last), .r_ready_i(r_ready),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o), .data_o(data_o),
        .data_i(data_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory returns {~addr, addr} one cycle after a read request.
    always @(posedge clock) if (req_o && !we_o) data_i <= {~addr_o, addr_o};

    always @(negedge clock) begin
        if (req_o) begin
            rq_addr.push_back(addr_o); rq_we.push_back(we_o);
            rq_be.push_back(be_o);     rq_data.push_back(data_o);
        end
        if (r_valid && r_ready) begin
            rb_data.push_back(r_data); rb_resp.push_back(r_resp); rb_last.push_back(r_last);
        end
        if (b_valid && b_ready) bq_resp.push_back(b_resp);
        if (ar_valid && ar_ready) gnt_q.push_back(1'b0);
        if (aw_valid && aw_ready) gnt_q.push_back(1'b1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rq_addr.delete(); rq_we.delete(); rq_be.delete(); rq_data.delete();
        rb_data.delete(); rb_resp.delete(); rb_last.delete();
        bq_resp.delete(); gnt_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_ar_hs(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (ar_ready) begin ok = 1'b1; break; end
        end
        chk("ar_handshake", ok, 1);
        @(posedge clock); #1 ar_valid = 1'b0;
    endtask

    task automatic wait_aw_hs(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (aw_ready) begin ok = 1'b1; break; end
        end
        chk("aw_handshake", ok, 1);
        @(posedge clock); #1 aw_valid = 1'b0;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b);
        ar_id = 4'h5; ar_addr = a; ar_len = l; ar_size = s; ar_burst = b; ar_valid = 1'b1;
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b);
        aw_id = 4'h3; aw_addr = a; aw_len = l; aw_size = s; aw_burst = b; aw_valid = 1'b1;
    endtask

    task automatic wait_rbeats(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (rb_data.size() >= n) break;
        end
        chk("r_beat_count", rb_data.size(), n);
        idle(3);
    endtask

    // Sends n W beats (strobes packed 8 bits per beat), then waits for B.
    task automatic w_send(input int n, input logic [31:0] strbs);
        bit ok;
        for (int k = 0; k < n; k++) begin
            w_valid = 1'b1; w_data = {32'hC0DE0000 + 32'(k), 32'(k)};
            w_strb = strbs[k*8 +: 8]; w_last = (k == n - 1);
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (w_ready) begin ok = 1'b1; break; end
            end
            chk("w_handshake", ok, 1);
            @(posedge clock); #1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bq_resp.size() >= 1) break;
        end
        chk("b_count", bq_resp.size(), 1);
        idle(3);
    endtask

    // Checks a read burst of n beats against expected addresses {e3,e2,e1,e0}.
    task automatic chk_rd(input int n, input logic [127:0] ea, input bit err);
        logic [31:0] a;
        chk("rd_req_count", rq_addr.size(), err ? 0 : n);
        for (int k = 0; k < n; k++) begin
            a = ea[k*32 +: 32];
            if (!err && k < rq_addr.size()) begin
                chk("rd_addr", rq_addr[k], a);
                chk("rd_we", rq_we[k], 0);
            end
            if (k < rb_data.size()) begin
                chk("r_data", rb_data[k], err ? 64'd0 : {~a, a});
                chk("r_resp", rb_resp[k], err ? 2'b10 : 2'b00);
                chk("r_last", rb_last[k], k == n - 1);
            end
        end
    endtask

    // AR and AW raised together; read must win, then the write follows.
    task automatic rr_pair();
        clear_logs();
        set_ar(32'h300, 8'd0, 3'd3, 2'b01);
        set_aw(32'h400, 8'd0, 3'd3, 2'b01);
        wait_ar_hs(20);
        wait_aw_hs(60);
        w_send(1, 32'h000000FF);
        chk("rr_grants", gnt_q.size(), 2);
        if (gnt_q.size() == 2) begin
            chk("rr_first_is_read", gnt_q[0], 1'b0);
            chk("rr_second_is_write", gnt_q[1], 1'b1);
        end
        chk("rr_read_beats", rb_data.size(), 1);
    endtask

    initial begin
        rst = 1'b1; data_i = '0;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0; r_ready = 0;
        repeat (2) @(negedge clock);
        chk("rst_readys", {ar_ready, aw_ready, w_ready}, 3'b000);
        chk("rst_valids", {r_valid, b_valid, r_last}, 3'b000);
        chk("rst_mem", {req_o, we_o}, 2'b00);
        chk("rst_data", {r_data, data_o}, 128'd0);
        chk("rst_id_resp", {r_id, b_id, r_resp, b_resp}, 12'd0);
        @(posedge clock); #1 rst = 1'b0;
        idle(2);

        // INCR read, 4 beats of 8 bytes
        clear_logs(); r_ready = 1'b1; b_ready = 1'b1;
        set_ar(32'h8000_0000, 8'd3, 3'd3, 2'b01);
        wait_ar_hs(20);
        wait_rbeats(4);
        chk_rd(4, {32'h8000_0018, 32'h8000_0010, 32'h8000_0008, 32'h8000_0000}, 1'b0);

        // INCR write, 2 beats with strobes FF then 0F
        clear_logs();
        set_aw(32'h1000, 8'd1, 3'd3, 2'b01);
        wait_aw_hs(20);
        w_send(2, 32'h00000FFF);
        chk("wr_req_count", rq_addr.size(), 2);
        if (rq_addr.size() == 2) begin
            chk("wr_addr0", rq_addr[0], 32'h1000);
            chk("wr_addr1", rq_addr[1], 32'h1008);
            chk("wr_we", {rq_we[0], rq_we[1]}, 2'b11);
            chk("wr_be0", rq_be[0], 8'hFF);
            chk("wr_be1", rq_be[1], 8'h0F);
            chk("wr_data0", rq_data[0], 64'hC0DE0000_00000000);
        end
        if (bq_resp.size() > 0) chk("wr_bresp", bq_resp[0], 2'b00);

        // Simultaneous AR/AW, twice
        rr_pair();
        rr_pair();

        // len=3 write terminated early by w_last on beat 2
        clear_logs();
        set_aw(32'h2000, 8'd3, 3'd3, 2'b01);
        wait_aw_hs(20);
        w_send(2, 32'h0000FFFF);
        chk("short_req_count", rq_addr.size(), 2);
        if (bq_resp.size() > 0) chk("short_bresp", bq_resp[0], 2'b10);

        // WRAP read at 0x18
        clear_logs();
        set_ar(32'h18, 8'd3, 3'd3, 2'b10);
        wait_ar_hs(20);
        wait_rbeats(4);
`ifdef BOOM_AXI_MEM_WRAP_EN
        chk_rd(4, {32'h10, 32'h08, 32'h00, 32'h18}, 1'b0);
`else
        chk_rd(4, {32'h30, 32'h28, 32'h20, 32'h18}, 1'b0);
`endif

        // Oversized beat: no memory access, SLVERR beats with zero data
        clear_logs();
        set_ar(32'h40, 8'd1, 3'd4, 2'b01);
        wait_ar_hs(20);
        wait_rbeats(2);
        chk_rd(2, {64'd0, 32'h48, 32'h40}, 1'b1);

        // Reset in the middle of a read burst with R stalled
        clear_logs(); r_ready = 1'b0;
        set_ar(32'h200, 8'd3, 3'd3, 2'b01);
        wait_ar_hs(20);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (r_valid) begin seen = 1'b1; break; end
            end
            chk("mid_rvalid_seen", seen, 1);
        end
        @(posedge clock); #1 rst = 1'b1;
        clear_logs();
        @(negedge clock);
        chk("mid_rst_rvalid", r_valid, 1'b0);
        chk("mid_rst_req", req_o, 1'b0);
        @(posedge clock); #1 rst = 1'b0; r_ready = 1'b1;
        repeat (6) @(negedge clock);
        chk("post_rst_req_count", rq_addr.size(), 0);
        chk("post_rst_beats", rb_data.size(), 0);
        chk("post_rst_idle", {r_valid, b_valid, w_ready}, 3'b000);

        // Round-robin restarts at read priority after reset
        rr_pair();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
